vga_frame_checker: RTL and testbench
====================================

// Module: vga_frame_checker
// PURPOSE
//  Synthesizable, parametrised VGA output checker for board-level self-test.
//  Taps the pixel stream (x/y/RGB + pixel strobe) beside VGA_unit and compares a rectangular view
//  window against expected pixels from an external source (SRAM reader/FIFO) over a ready/valid port.
//  Counts per-channel mismatches over one frame and reports pass/fail, so LEDs/7-seg show the result.
// PARAMETERS
//  NUM_CH          3     colour channels per pixel
//  CH_WIDTH        10    bits per channel on the VGA side
//  EXP_WIDTH       8     bits per expected channel; expected value = {exp, (CH_WIDTH-EXP_WIDTH) zeros}
//  COORD_WIDTH     10    pixel x/y width
//  VIEW_LEFT       160   first checked column (inclusive)
//  VIEW_RIGHT      480   last checked column (exclusive)
//  VIEW_TOP        120   first checked row (inclusive)
//  VIEW_BOTTOM     360   last checked row (exclusive)
//  MAX_MISMATCHES  10    halt once mismatch count exceeds this
//  CNT_WIDTH       16    width of mismatch and pixel counters
// PORTS
//  Clock_50        in   1                     system clock
//  Resetn          in   1                     asynchronous active-low reset
//  start_i         in   1                     pulse: arm checker (accepted in IDLE/DONE/HALT)
//  abort_i         in   1                     pulse: return to IDLE, highest priority
//  vsync_n_i       in   1                     VGA vertical sync, active low
//  pix_en_i        in   1                     pixel strobe, one pulse per displayed pixel
//  pix_x_i         in   COORD_WIDTH           column of the current pixel
//  pix_y_i         in   COORD_WIDTH           row of the current pixel
//  pix_data_i      in   NUM_CH*CH_WIDTH       pixel data, channel 0 (red) in MSBs
//  exp_valid_i     in   1                     expected word available
//  exp_data_i      in   NUM_CH*EXP_WIDTH      expected pixel data, channel 0 in MSBs
//  exp_ready_o     out  1                     expected word consumed this cycle (combinational)
//  busy_o          out  1                     state is ARMED, SYNC or CHECK
//  done_o          out  1                     frame finished without halt
//  pass_o          out  1                     done_o && mismatch count == 0 && !underflow_o
//  halt_o          out  1                     stopped early (mismatch limit or underflow)
//  underflow_o     out  1                     sticky: in-window pixel arrived with exp_valid_i low
//  mismatch_cnt_o  out  CNT_WIDTH             channel mismatches this frame (saturating)
//  pixel_cnt_o     out  CNT_WIDTH             in-window pixels compared (saturating)
//  first_x_o       out  COORD_WIDTH           column of first mismatch (only with FIRST_MISMATCH_EN)
//  first_y_o       out  COORD_WIDTH           row of first mismatch (only with FIRST_MISMATCH_EN)
// BEHAVIOUR
//  Reset: state IDLE; all outputs, counters and flags 0.
//  FSM:
//   IDLE  -start_i->      ARMED; clears counters, flags and done/halt
//   ARMED -vsync_n_i==0-> SYNC
//   SYNC  -vsync_n_i==1-> CHECK
//   CHECK -vsync_n_i 1->0 edge-> DONE
//   CHECK -limit/underflow-> HALT
//   DONE/HALT hold results; start_i re-arms (-> ARMED, clears); abort_i from any state -> IDLE
//   start_i ignored in ARMED, SYNC and CHECK.
//  Window: hit = CHECK && pix_en_i && VIEW_LEFT<=x<VIEW_RIGHT && VIEW_TOP<=y<VIEW_BOTTOM.
//  exp_ready_o = hit && exp_valid_i; exactly one expected word per hit pixel.
//  Compare: on hit with exp_valid_i, each channel != padded expected adds 1 (0..NUM_CH per pixel).
//   pixel_cnt_o += 1. All counters saturate at all-ones. Results are registered one cycle after the pixel.
//  Underflow: hit with exp_valid_i low sets underflow_o; no compare; -> HALT next cycle.
//  Limit: registered mismatch_cnt_o > MAX_MISMATCHES -> HALT next cycle; later pixels are ignored.
//  Simultaneous: hit in the same cycle as the vsync falling edge is still compared, then DONE.
//   Limit crossing and vsync fall in the same cycle -> HALT wins. abort_i beats everything.
//  Edge detect uses a registered vsync_n_i; no pixels are compared outside CHECK.
// CONFIGURATION
//  FIRST_MISMATCH_EN defined: first_x_o/first_y_o latch the coordinates of the first pixel with any
//   channel mismatch in the frame. They hold until re-arm, are cleared to 0 on arm/reset,
//   and equal 0 if no mismatch occurs.
//  Not defined: first_x_o/first_y_o tied to 0, no capture registers.
// TESTING
//  1 Matching frame, 320x240 window, exp always valid -> done_o=1, pass_o=1, pixel_cnt_o=76800,
//    mismatch_cnt_o=0.
//  2 Pixel (200,130) red wrong, green wrong -> mismatch_cnt_o=2, pass_o=0, done_o=1;
//    with macro first_x_o=200, first_y_o=130.
//  3 Every pixel from (160,120) wrong in all 3 channels -> after 4th pixel count=12>10,
//    halt_o=1, done_o=0, count frozen at 12.
//  4 exp_valid_i held low at pixel (170,120) -> underflow_o=1, halt_o=1, pixel_cnt_o=10.
//  5 Pixels at x=159, x=480, y=119, y=360 carry wrong data -> exp_ready_o stays 0 for them,
//    mismatch_cnt_o=0.
//  6 abort_i mid-CHECK, then start_i -> IDLE, then counters cleared, busy_o=1;
//    Resetn low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/vga_frame_checker_if.sv
// Pixel tap and expected-pixel stream bundle for vga_frame_checker.
//   master : pixel source / expected-word source (board logic or testbench)
//   slave  : the frame checker
// Signals:
//   vsync_n_i   vertical sync, active low
//   pix_en_i    one strobe per displayed pixel
//   pix_x_i     column of the current pixel
//   pix_y_i     row of the current pixel
//   pix_data_i  NUM_CH channels of CH_WIDTH bits, channel 0 in MSBs
//   exp_valid_i expected word available
//   exp_data_i  NUM_CH channels of EXP_WIDTH bits, channel 0 in MSBs
//   exp_ready_o expected word consumed this cycle
interface vga_frame_checker_if #(
    parameter int NUM_CH      = 3,
    parameter int CH_WIDTH    = 10,
    parameter int EXP_WIDTH   = 8,
    parameter int COORD_WIDTH = 10
) ();
    logic                          vsync_n_i;
    logic                          pix_en_i;
    logic [COORD_WIDTH-1:0]        pix_x_i;
    logic [COORD_WIDTH-1:0]        pix_y_i;
    logic [NUM_CH*CH_WIDTH-1:0]    pix_data_i;
    logic                          exp_valid_i;
    logic [NUM_CH*EXP_WIDTH-1:0]   exp_data_i;
    logic                          exp_ready_o;

    modport master (
        output vsync_n_i, pix_en_i, pix_x_i, pix_y_i, pix_data_i,
        output exp_valid_i, exp_data_i,
        input  exp_ready_o
    );

    modport slave (
        input  vsync_n_i, pix_en_i, pix_x_i, pix_y_i, pix_data_i,
        input  exp_valid_i, exp_data_i,
        output exp_ready_o
    );
endinterface

// File: rtl/vga_frame_checker.sv
// vga_frame_checker
//   Taps the VGA pixel stream and compares a rectangular view window
//   against expected pixels delivered over a ready/valid port. Counts
//   per-channel mismatches over one frame and reports pass/fail.
// Optional feature macro: FIRST_MISMATCH_EN
//   defined     : first_x_o/first_y_o hold the coordinates of the first
//                 mismatching pixel of the frame
//   not defined : first_x_o/first_y_o tied to 0
// Ports:
//   Clock_50        system clock
//   Resetn          asynchronous active-low reset
//   start_i         arm pulse (accepted in IDLE/DONE/HALT)
//   abort_i         return to IDLE, highest priority
//   vif             pixel tap + expected stream (slave modport)
//   busy_o          ARMED, SYNC or CHECK
//   done_o          frame finished without halt
//   pass_o          done with zero mismatches and no underflow
//   halt_o          stopped early (limit or underflow)
//   underflow_o     sticky: in-window pixel without expected word
//   mismatch_cnt_o  channel mismatches this frame (saturating)
//   pixel_cnt_o     in-window pixels compared (saturating)
//   first_x_o/first_y_o  first mismatch coordinates (macro only)
module vga_frame_checker #(
    parameter int NUM_CH         = 3,
    parameter int CH_WIDTH       = 10,
    parameter int EXP_WIDTH      = 8,
    parameter int COORD_WIDTH    = 10,
    parameter int VIEW_LEFT      = 160,
    parameter int VIEW_RIGHT     = 480,
    parameter int VIEW_TOP       = 120,
    parameter int VIEW_BOTTOM    = 360,
    parameter int MAX_MISMATCHES = 10,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                   Clock_50,
    input  logic                   Resetn,
    input  logic                   start_i,
    input  logic                   abort_i,
    vga_frame_checker_if.slave     vif,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic                   halt_o,
    output logic                   underflow_o,
    output logic [CNT_WIDTH-1:0]   mismatch_cnt_o,
    output logic [CNT_WIDTH-1:0]   pixel_cnt_o,
    output logic [COORD_WIDTH-1:0] first_x_o,
    output logic [COORD_WIDTH-1:0] first_y_o
);
    localparam int PIX_W = NUM_CH * CH_WIDTH;
    localparam int EXP_W = NUM_CH * EXP_WIDTH;
    localparam int PAD_W = CH_WIDTH - EXP_WIDTH;

    localparam logic [COORD_WIDTH-1:0] X_LO = COORD_WIDTH'(VIEW_LEFT);
    localparam logic [COORD_WIDTH-1:0] X_HI = COORD_WIDTH'(VIEW_RIGHT);
    localparam logic [COORD_WIDTH-1:0] Y_LO = COORD_WIDTH'(VIEW_TOP);
    localparam logic [COORD_WIDTH-1:0] Y_HI = COORD_WIDTH'(VIEW_BOTTOM);
    localparam logic [CNT_WIDTH-1:0]   LIMIT   = CNT_WIDTH'(MAX_MISMATCHES);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_SYNC  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_HALT  = 3'd5
    } state_e;

    // Number of channels whose pixel value differs from the zero-padded expected value.
    function automatic logic [CNT_WIDTH-1:0] count_ch_mismatch(
        input logic [PIX_W-1:0] pix,
        input logic [EXP_W-1:0] exp_w
    );
        logic [CNT_WIDTH-1:0] n;
        logic [CH_WIDTH-1:0]  padded;
        n = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            padded = CH_WIDTH'(exp_w[c*EXP_WIDTH +: EXP_WIDTH]) << PAD_W;
            if (pix[c*CH_WIDTH +: CH_WIDTH] != padded) begin
                n = n + CNT_ONE;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Add with clamp at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] a,
        input logic [CNT_WIDTH-1:0] b
    );
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[CNT_WIDTH]) begin
            return '1;
        end else begin
            return s[CNT_WIDTH-1:0];
        end
    endfunction

    state_e               state_q;
    logic                 vsync_q;
    logic                 busy_q, done_q, pass_q, halt_q, underflow_q;
    logic [CNT_WIDTH-1:0] mismatch_cnt_q, mismatch_cnt_d;
    logic [CNT_WIDTH-1:0] pixel_cnt_q, pixel_cnt_d;
    logic [CNT_WIDTH-1:0] pix_mm_s;
    logic                 in_window_s, stop_s, hit_s, compare_s, starve_s;
    logic                 vsync_fall_s, arm_s;

    assign in_window_s = (vif.pix_x_i >= X_LO) && (vif.pix_x_i < X_HI) &&
                         (vif.pix_y_i >= Y_LO) && (vif.pix_y_i < Y_HI);

    // Once the limit is exceeded or underflow is flagged, the frame is already
    // lost: further pixels are neither compared nor consumed.
    assign stop_s    = (mismatch_cnt_q > LIMIT) || underflow_q;
    assign hit_s     = (state_q == ST_CHECK) && !abort_i && !stop_s &&
                       vif.pix_en_i && in_window_s;
    assign compare_s = hit_s && vif.exp_valid_i;
    assign starve_s  = hit_s && !vif.exp_valid_i;
    assign vif.exp_ready_o = compare_s;

    assign vsync_fall_s = vsync_q && !vif.vsync_n_i;
    assign arm_s = start_i && !abort_i &&
                   ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_HALT));

    // Per-pixel mismatch count and next counter values.
    always_comb begin
        pix_mm_s       = count_ch_mismatch(vif.pix_data_i, vif.exp_data_i);
        mismatch_cnt_d = mismatch_cnt_q;
        pixel_cnt_d    = pixel_cnt_q;
        if (compare_s) begin
            mismatch_cnt_d = sat_add(mismatch_cnt_q, pix_mm_s);
            pixel_cnt_d    = sat_add(pixel_cnt_q, CNT_ONE);
        end else begin
            mismatch_cnt_d = mismatch_cnt_q;
            pixel_cnt_d    = pixel_cnt_q;
        end
    end

    // Control FSM, counters and registered status flags.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q        <= ST_IDLE;
            vsync_q        <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            halt_q         <= 1'b0;
            underflow_q    <= 1'b0;
            mismatch_cnt_q <= '0;
            pixel_cnt_q    <= '0;
        end else begin
            vsync_q <= vif.vsync_n_i;
            if (abort_i) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
                pass_q  <= 1'b0;
                halt_q  <= 1'b0;
            end else if (arm_s) begin
                state_q        <= ST_ARMED;
                busy_q         <= 1'b1;
                done_q         <= 1'b0;
                pass_q         <= 1'b0;
                halt_q         <= 1'b0;
                underflow_q    <= 1'b0;
                mismatch_cnt_q <= '0;
                pixel_cnt_q    <= '0;
            end else begin
                case (state_q)
                    ST_ARMED: begin
                        if (!vif.vsync_n_i) begin
                            state_q <= ST_SYNC;
                        end else begin
                            state_q <= ST_ARMED;
                        end
                    end
                    ST_SYNC: begin
                        if (vif.vsync_n_i) begin
                            state_q <= ST_CHECK;
                        end else begin
                            state_q <= ST_SYNC;
                        end
                    end
                    ST_CHECK: begin
                        if (stop_s) begin
                            state_q <= ST_HALT;
                            busy_q  <= 1'b0;
                            halt_q  <= 1'b1;
                        end else begin
                            mismatch_cnt_q <= mismatch_cnt_d;
                            pixel_cnt_q    <= pixel_cnt_d;
                            if (starve_s) begin
                                underflow_q <= 1'b1;
                                state_q     <= ST_HALT;
                                busy_q      <= 1'b0;
                                halt_q      <= 1'b1;
                            end else if (vsync_fall_s) begin
                                busy_q <= 1'b0;
                                // A limit crossing on the last pixel still counts as a halt.
                                if (mismatch_cnt_d > LIMIT) begin
                                    state_q <= ST_HALT;
                                    halt_q  <= 1'b1;
                                end else begin
                                    state_q <= ST_DONE;
                                    done_q  <= 1'b1;
                                    pass_q  <= (mismatch_cnt_d == '0);
                                end
                            end else begin
                                state_q <= ST_CHECK;
                            end
                        end
                    end
                    ST_IDLE, ST_DONE, ST_HALT: begin
                        state_q <= state_q;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        halt_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign pass_o         = pass_q;
    assign halt_o         = halt_q;
    assign underflow_o    = underflow_q;
    assign mismatch_cnt_o = mismatch_cnt_q;
    assign pixel_cnt_o    = pixel_cnt_q;

`ifdef FIRST_MISMATCH_EN
    logic [COORD_WIDTH-1:0] first_x_q, first_y_q;

    // Latch coordinates of the first mismatching pixel; a zero mismatch count
    // means nothing has been captured yet this frame.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            first_x_q <= '0;
            first_y_q <= '0;
        end else if (arm_s) begin
            first_x_q <= '0;
            first_y_q <= '0;
        end else if (compare_s && (pix_mm_s != '0) && (mismatch_cnt_q == '0)) begin
            first_x_q <= vif.pix_x_i;
            first_y_q <= vif.pix_y_i;
        end else begin
            first_x_q <= first_x_q;
            first_y_q <= first_y_q;
        end
    end

    assign first_x_o = first_x_q;
    assign first_y_o = first_y_q;
`else
    assign first_x_o = '0;
    assign first_y_o = '0;
`endif
endmodule

// File: tb/tb_vga_frame_checker.sv
module tb_vga_frame_checker;
    localparam int CW = 17;   // wide enough to hold a full 320x240 window count
`ifdef FIRST_MISMATCH_EN
    localparam bit FM = 1'b1;
`else
    localparam bit FM = 1'b0;
`endif

    logic          Clock_50 = 1'b0;
    logic          Resetn;
    logic          start_i, abort_i;
    logic          busy_o, done_o, pass_o, halt_o, underflow_o;
    logic [CW-1:0] mismatch_cnt_o, pixel_cnt_o;
    logic [9:0]    first_x_o, first_y_o;

    vga_frame_checker_if #(.NUM_CH(3), .CH_WIDTH(10), .EXP_WIDTH(8), .COORD_WIDTH(10)) vif();

    vga_frame_checker #(.CNT_WIDTH(CW)) dut (
        .Clock_50      (Clock_50),
        .Resetn        (Resetn),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .vif           (vif),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .pass_o        (pass_o),
        .halt_o        (halt_o),
        .underflow_o   (underflow_o),
        .mismatch_cnt_o(mismatch_cnt_o),
        .pixel_cnt_o   (pixel_cnt_o),
        .first_x_o     (first_x_o),
        .first_y_o     (first_y_o)
    );

    always #5 Clock_50 = ~Clock_50;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        st, ab, vs, pe;
        logic [9:0]  x, y;
        logic [29:0] pix;
        logic        ev;
        logic [23:0] ed;
        logic        rdy, busy, done, pass, halt, uf;
        logic [CW-1:0] mm, pc;
        logic [9:0]  fx, fy;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic rdy_s;

    function automatic logic [29:0] pad(input logic [23:0] e);
        return {e[23:16], 2'b00, e[15:8], 2'b00, e[7:0], 2'b00};
    endfunction

    function automatic vec_t mk(
        input logic st, input logic ab, input logic vs, input logic pe,
        input int x, input int y, input logic [29:0] pix, input logic ev, input logic [23:0] ed,
        input logic rdy, input logic busy, input logic done, input logic pass,
        input logic halt, input logic uf, input int mm, input int pc, input int fx, input int fy
    );
        vec_t v;
        v.st = st; v.ab = ab; v.vs = vs; v.pe = pe;
        v.x = 10'(x); v.y = 10'(y); v.pix = pix; v.ev = ev; v.ed = ed;
        v.rdy = rdy; v.busy = busy; v.done = done; v.pass = pass; v.halt = halt; v.uf = uf;
        v.mm = CW'(mm); v.pc = CW'(pc); v.fx = 10'(fx); v.fy = 10'(fy);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs; exp_ready_o is sampled at the falling edge,
    // registered outputs one time unit after the rising edge.
    task automatic cyc(input logic st, input logic ab, input logic vs, input logic pe,
                       input int x, input int y, input logic [29:0] pix,
                       input logic ev, input logic [23:0] ed);
        start_i = st; abort_i = ab;
        vif.vsync_n_i = vs; vif.pix_en_i = pe;
        vif.pix_x_i = 10'(x); vif.pix_y_i = 10'(y);
        vif.pix_data_i = pix; vif.exp_valid_i = ev; vif.exp_data_i = ed;
        @(negedge Clock_50);
        rdy_s = vif.exp_ready_o;
        @(posedge Clock_50);
        #1;
    endtask

    task automatic idle(input logic vs);
        cyc(1'b0, 1'b0, vs, 1'b0, 0, 0, 30'd0, 1'b1, 24'd0);
    endtask

    task automatic arm();
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 30'd0, 1'b1, 24'd0);
    endtask

    task automatic enter_check();
        idle(1'b0);
        idle(1'b1);
    endtask

    task automatic status(input string tag, input logic busy, input logic done, input logic pass,
                          input logic halt, input logic uf, input int mm, input int pc);
        check({tag, ".busy"}, 64'(busy_o), 64'(busy));
        check({tag, ".done"}, 64'(done_o), 64'(done));
        check({tag, ".pass"}, 64'(pass_o), 64'(pass));
        check({tag, ".halt"}, 64'(halt_o), 64'(halt));
        check({tag, ".underflow"}, 64'(underflow_o), 64'(uf));
        check({tag, ".mismatch_cnt"}, 64'(mismatch_cnt_o), 64'(mm));
        check({tag, ".pixel_cnt"}, 64'(pixel_cnt_o), 64'(pc));
    endtask

    initial begin
        logic [23:0] e_w, e_xy;
        logic [29:0] p_good, p_rg, p_all;
        int fx, fy, miss;

        e_w    = 24'h112233;
        p_good = pad(e_w);
        p_rg   = p_good ^ {10'h004, 10'h001, 10'h000};  // red and green wrong
        p_all  = ~p_good;                               // all three channels wrong
        fx = FM ? 200 : 0;
        fy = FM ? 130 : 0;

        //         st ab vs pe  x    y    pix     ev ed   rdy bsy dn ps ht uf mm pc fx  fy
        tbl.push_back(mk(0, 0, 1, 0, 0,   0,   p_good, 1, e_w, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(1, 0, 1, 0, 0,   0,   p_good, 1, e_w, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 0, 0, 0, 0,   0,   p_good, 1, e_w, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 0, 0, 0, 0,   0,   p_good, 1, e_w, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 0, 1, 0, 0,   0,   p_good, 1, e_w, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 0, 1, 1, 159, 130, p_all,  1, e_w, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 0, 1, 1, 480, 130, p_all,  1, e_w, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 0, 1, 1, 200, 119, p_all,  1, e_w, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 0, 1, 1, 200, 360, p_all,  1, e_w, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(1, 0, 1, 1, 160, 120, p_good, 1, e_w, 1, 1, 0, 0, 0, 0, 0, 1, 0,  0));
        tbl.push_back(mk(0, 0, 1, 1, 200, 130, p_rg,   1, e_w, 1, 1, 0, 0, 0, 0, 2, 2, fx, fy));
        tbl.push_back(mk(0, 0, 1, 0, 161, 120, p_all,  1, e_w, 0, 1, 0, 0, 0, 0, 2, 2, fx, fy));
        tbl.push_back(mk(0, 0, 0, 1, 161, 120, p_good, 1, e_w, 1, 0, 1, 0, 0, 0, 2, 3, fx, fy));
        tbl.push_back(mk(0, 0, 0, 0, 0,   0,   p_good, 1, e_w, 0, 0, 1, 0, 0, 0, 2, 3, fx, fy));
        tbl.push_back(mk(0, 1, 1, 0, 0,   0,   p_good, 1, e_w, 0, 0, 0, 0, 0, 0, 2, 3, fx, fy));
        tbl.push_back(mk(1, 0, 1, 0, 0,   0,   p_good, 1, e_w, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0));

        // Reset
        Resetn = 1'b0;
        start_i = 1'b0; abort_i = 1'b0;
        vif.vsync_n_i = 1'b1; vif.pix_en_i = 1'b0; vif.pix_x_i = 10'd0; vif.pix_y_i = 10'd0;
        vif.pix_data_i = 30'd0; vif.exp_valid_i = 1'b0; vif.exp_data_i = 24'd0;
        repeat (3) @(posedge Clock_50);
        @(negedge Clock_50);
        Resetn = 1'b1;
        @(posedge Clock_50);
        #1;

        // Table: window boundaries, padded compare, start ignored, last-pixel-with-vsync, abort, re-arm
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            cyc(v.st, v.ab, v.vs, v.pe, int'(v.x), int'(v.y), v.pix, v.ev, v.ed);
            check($sformatf("vec%0d", i),
                  {4'h0, rdy_s, busy_o, done_o, pass_o, halt_o, underflow_o,
                   mismatch_cnt_o, pixel_cnt_o, first_x_o, first_y_o},
                  {4'h0, v.rdy, v.busy, v.done, v.pass, v.halt, v.uf, v.mm, v.pc, v.fx, v.fy});
        end

        // Full matching frame over the 320x240 window (state is ARMED here)
        enter_check();
        miss = 0;
        for (int y = 120; y < 360; y++) begin
            for (int x = 160; x < 480; x++) begin
                logic [9:0] xv, yv;
                xv = 10'(x); yv = 10'(y);
                e_xy = {xv[7:0], yv[7:0], xv[7:0] ^ yv[7:0]};
                cyc(1'b0, 1'b0, 1'b1, 1'b1, x, y, pad(e_xy), 1'b1, e_xy);
                if (rdy_s !== 1'b1) miss++;
            end
        end
        idle(1'b0);
        check("full.ready_misses", 64'(miss), 64'd0);
        status("full", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 76800);
        check("full.first_x", 64'(first_x_o), 64'd0);
        idle(1'b1);

        // Mismatch limit: every channel wrong from (160,120)
        arm();
        enter_check();
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 160 + k, 120, p_all, 1'b1, e_w);
            if (k == 3) status("limit.k3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12, 4);
            if (k == 4) begin
                check("limit.k4_ready", 64'(rdy_s), 64'd0);
                check("limit.k4_halt", 64'(halt_o), 64'd1);
            end
        end
        status("limit", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12, 4);
        check("limit.first_x", 64'(first_x_o), FM ? 64'd160 : 64'd0);
        check("limit.first_y", 64'(first_y_o), FM ? 64'd120 : 64'd0);
        idle(1'b0);
        check("limit.hold_halt", {62'd0, halt_o, done_o}, 64'd2);
        idle(1'b1);

        // Underflow: expected word missing at (170,120)
        arm();
        status("rearm", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        enter_check();
        for (int x = 160; x < 170; x++) cyc(1'b0, 1'b0, 1'b1, 1'b1, x, 120, p_good, 1'b1, e_w);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 170, 120, p_good, 1'b0, e_w);
        check("uf.ready", 64'(rdy_s), 64'd0);
        status("uf", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 10);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 171, 120, p_good, 1'b1, e_w);
        check("uf.after_ready", 64'(rdy_s), 64'd0);
        check("uf.after_pc", 64'(pixel_cnt_o), 64'd10);

        // Limit crossing on the vsync-fall cycle: halt wins over done
        arm();
        enter_check();
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 160 + k, 200, p_all, 1'b1, e_w);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 163, 200, p_all, 1'b1, e_w);
        check("race.ready", 64'(rdy_s), 64'd1);
        status("race", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12, 4);
        idle(1'b1);

        // Abort mid-CHECK beats a hit pixel, then re-arm clears
        arm();
        enter_check();
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 300, 300, p_good, 1'b1, e_w);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 301, 300, p_good, 1'b1, e_w);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 302, 300, p_all, 1'b1, e_w);
        check("abort.ready", 64'(rdy_s), 64'd0);
        status("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2);
        arm();
        status("abort.rearm", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        // Asynchronous reset mid-frame
        enter_check();
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 200, 130, p_rg, 1'b1, e_w);
        status("prereset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1);
        vif.pix_en_i = 1'b1; vif.pix_x_i = 10'd201; vif.exp_valid_i = 1'b1;
        #2;
        Resetn = 1'b0;
        #1;
        status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check("reset.ready", 64'(vif.exp_ready_o), 64'd0);
        check("reset.first", {44'd0, first_x_o, first_y_o}, 64'd0);
        @(negedge Clock_50);
        @(negedge Clock_50);
        Resetn = 1'b1;
        @(posedge Clock_50);
        #1;
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 202, 130, p_all, 1'b1, e_w);
        check("reset.idle_ready", 64'(rdy_s), 64'd0);
        check("reset.idle_busy", 64'(busy_o), 64'd0);
        arm();
        check("reset.arm_busy", 64'(busy_o), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
